// File: rtl/ctrl_sequencer.sv
// Multi-cycle fetch/decode/execute control unit for the accumulator datapath.
// Drives register load enables and memory strobes with a mem_ready handshake.
module ctrl_sequencer #(
  parameter int OPW  = 4,
  parameter int ALUW = 3
) (
  input  logic            clk,
  input  logic            clr,
  input  logic            run,
  input  logic [OPW-1:0]  opcode,
  input  logic            zero,
  input  logic            mem_ready,
  output logic            pc_load,
  output logic            pc_inc,
  output logic            mar_load,
  output logic            mar_sel,
  output logic            mdr_load,
  output logic            ir_load,
  output logic            acc_load,
  output logic            mem_rd,
  output logic            mem_wr,
  output logic [ALUW-1:0] alu_op,
  output logic            halted,
  output logic            illegal,
  output logic [3:0]      state
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_F_ADDR = 4'd1,
    S_F_MEM  = 4'd2,
    S_F_IR   = 4'd3,
    S_DECODE = 4'd4,
    S_E_MRD  = 4'd5,
    S_E_WB   = 4'd6,
    S_E_MWR  = 4'd7,
    S_E_BR   = 4'd8,
    S_HALT   = 4'd9
  } state_t;

  state_t         r_state;
  state_t         w_next;
  state_t         w_bound;
  logic [OPW-1:0] r_op;

  logic w_rd_op;
  logic w_st_op;
  logic w_br_op;
  logic w_hlt_op;
  logic w_ill_op;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_state <= S_IDLE;
      r_op    <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE)
        r_op <= opcode;
    end
  end

  assign w_rd_op  = (opcode == OPW'(1)) || (opcode == OPW'(3)) ||
                    (opcode == OPW'(4)) || (opcode == OPW'(5));
  assign w_st_op  = (opcode == OPW'(2));
  assign w_br_op  = (opcode == OPW'(6)) ||
                    ((opcode == OPW'(7)) && zero);
  assign w_hlt_op = (opcode == OPW'(15));
  assign w_ill_op = !((opcode <= OPW'(7)) || w_hlt_op);
  assign w_bound  = run ? S_F_ADDR : S_IDLE;
  assign state    = r_state;

  always_comb begin
    w_next   = r_state;
    pc_load  = 1'b0;
    pc_inc   = 1'b0;
    mar_load = 1'b0;
    mar_sel  = 1'b0;
    mdr_load = 1'b0;
    ir_load  = 1'b0;
    acc_load = 1'b0;
    mem_rd   = 1'b0;
    mem_wr   = 1'b0;
    alu_op   = '0;
    halted   = 1'b0;
    illegal  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (run)
          w_next = S_F_ADDR;
      end
      S_F_ADDR: begin
        mar_load = 1'b1;
        w_next   = S_F_MEM;
      end
      S_F_MEM: begin
        mem_rd = 1'b1;
        if (mem_ready) begin
          mdr_load = 1'b1;
          pc_inc   = 1'b1;
          w_next   = S_F_IR;
        end
      end
      S_F_IR: begin
        ir_load = 1'b1;
        w_next  = S_DECODE;
      end
      S_DECODE: begin
        unique case (1'b1)
          w_rd_op: begin
            mar_load = 1'b1;
            mar_sel  = 1'b1;
            w_next   = S_E_MRD;
          end
          w_st_op: begin
            mar_load = 1'b1;
            mar_sel  = 1'b1;
            w_next   = S_E_MWR;
          end
          w_br_op:  w_next = S_E_BR;
          w_hlt_op: w_next = S_HALT;
          w_ill_op: begin
            illegal = 1'b1;
            w_next  = w_bound;
          end
          default:  w_next = w_bound;
        endcase
      end
      S_E_MRD: begin
        mem_rd = 1'b1;
        if (mem_ready) begin
          mdr_load = 1'b1;
          w_next   = S_E_WB;
        end
      end
      S_E_WB: begin
        acc_load = 1'b1;
        // LOAD passes memory data straight through to ACC
        case (r_op)
          OPW'(3): alu_op = ALUW'(1);
          OPW'(4): alu_op = ALUW'(2);
          OPW'(5): alu_op = ALUW'(3);
          default: alu_op = ALUW'(0);
        endcase
        w_next = w_bound;
      end
      S_E_MWR: begin
        mem_wr = 1'b1;
        if (mem_ready)
          w_next = w_bound;
      end
      S_E_BR: begin
        pc_load = 1'b1;
        w_next  = w_bound;
      end
      S_HALT: begin
        halted = 1'b1;
      end
      default: w_next = S_IDLE;
    endcase
  end

endmodule
